// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the load/store alignment unit.
//   - RV32I funct3 width/sign codes (F3_*)
//   - FSM state encoding (ST_*)
//   - per-width lane size masks (MASK_*)
//   - helpers: size_mask() and f3_legal()
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FIRST  = 2'd1;
   localparam logic [1:0] ST_SECOND = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // Unsigned variants share the low two bits with the signed ones.
   function automatic logic [3:0] size_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_mask = MASK_B;
         2'b01:   size_mask = MASK_H;
         default: size_mask = MASK_W;
      endcase
   endfunction

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else    f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                         (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: combinational load-result extension.
//   funct3 : in  3  width/sign code of the load
//   raw    : in  32 assembled, right-justified load word
//   ext    : out 32 sign- or zero-extended result
module lsu_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      case (funct3)
         F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
         F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
         F3_BU:   ext = {24'h0, raw[7:0]};
         F3_HU:   ext = {16'h0, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit in front of a word-organised data memory.
// Build option: MISALIGN_SPLIT_EN -- when defined, word-crossing accesses are
// split into two memory cycles; otherwise they complete with resp_err=1.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_we/funct3/addr/wdata     request payload (byte address, right-justified data)
//   resp_valid/rdata/err         one-cycle completion pulse and result
//   address_dm/writedata_dm/byte_en/memread_dm/memwrite_dm  memory drive
//   mem_data                     combinational memory read word
module lsu_align
   import lsu_pkg::*;
#(
   parameter int ADDR_BITS = 10
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [31:0]          req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 resp_valid,
   output logic [31:0]          resp_rdata,
   output logic                 resp_err,
   output logic [ADDR_BITS-1:0] address_dm,
   output logic [31:0]          writedata_dm,
   output logic [3:0]           byte_en,
   output logic                 memread_dm,
   output logic                 memwrite_dm,
   input  logic [31:0]          mem_data
);

`ifdef MISALIGN_SPLIT_EN
   localparam logic SPLIT_EN = 1'b1;
`else
   localparam logic SPLIT_EN = 1'b0;
`endif

   logic [1:0]           state_q, state_d;
   logic                 we_q, we_d;
   logic [2:0]           f3_q, f3_d;
   logic [ADDR_BITS+1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          buf_q, buf_d;

   logic [1:0]           off;
   logic [7:0]           lane8;
   logic                 crossing;
   logic                 err;
   logic [ADDR_BITS-1:0] word_a, word_b;
   logic [4:0]           sh_lo;
   logic [5:0]           sh_hi;
   logic [31:0]          ext_word;

   // Address bits above the memory window wrap silently.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

   assign off      = addr_q[1:0];
   assign lane8    = {4'b0000, size_mask(f3_q)} << off;
   assign crossing = |lane8[7:4];
   assign err      = !f3_legal(we_q, f3_q) || (crossing && !SPLIT_EN);
   assign word_a   = addr_q[ADDR_BITS+1:2];
   assign word_b   = word_a + {{(ADDR_BITS-1){1'b0}}, 1'b1};  // wraps to 0
   assign sh_lo    = {off, 3'b000};
   // Only used in SECOND, where off is 1..3, so the shift stays below 32.
   assign sh_hi    = 6'd32 - {1'b0, off, 3'b000};

   lsu_extend u_extend (
      .funct3 (f3_q),
      .raw    (buf_q),
      .ext    (ext_word)
   );

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      f3_d         = f3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      buf_d        = buf_q;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_rdata   = 32'h0;
      resp_err     = 1'b0;
      address_dm   = '0;
      writedata_dm = 32'h0;
      byte_en      = 4'h0;
      memread_dm   = 1'b0;
      memwrite_dm  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr[ADDR_BITS+1:0];
               wdata_d = req_wdata;
               buf_d   = 32'h0;
               state_d = ST_FIRST;
            end
         end
         ST_FIRST: begin
            address_dm = word_a;
            if (!err) begin
               if (we_q) begin
                  memwrite_dm  = 1'b1;
                  byte_en      = lane8[3:0];
                  writedata_dm = wdata_q << sh_lo;
               end else begin
                  memread_dm = 1'b1;
                  buf_d      = mem_data >> sh_lo;
               end
            end
            state_d = (crossing && !err) ? ST_SECOND : ST_RESP;
         end
         ST_SECOND: begin
            address_dm = word_b;
            if (we_q) begin
               memwrite_dm  = 1'b1;
               byte_en      = lane8[7:4];
               writedata_dm = wdata_q >> sh_hi;
            end else begin
               memread_dm = 1'b1;
               buf_d      = buf_q | (mem_data << sh_hi);
            end
            state_d = ST_RESP;
         end
         default: begin  // ST_RESP
            resp_valid = 1'b1;
            resp_err   = err;
            resp_rdata = (!we_q && !err) ? ext_word : 32'h0;
            state_d    = ST_IDLE;
         end
      endcase

      // Reset blocks the memory strobes in the same cycle, so an aborted
      // split access never commits its second half at the reset edge.
      if (rst) begin
         req_ready    = 1'b1;
         resp_valid   = 1'b0;
         resp_rdata   = 32'h0;
         resp_err     = 1'b0;
         address_dm   = '0;
         writedata_dm = 32'h0;
         byte_en      = 4'h0;
         memread_dm   = 1'b0;
         memwrite_dm  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         buf_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
      end
   end

endmodule
